wrf_rx_check: RTL and testbench

//  WR fabric receive-side frame checker; downstream consumer of the 16-bit WR fabric

---
 rtl/wrf_rx_check.sv | 175 +++++++++++++++++
 tb/tb_wrf_rx_check.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrf_rx_check.sv
`default_nettype none
// ============================================================================
//  Module   : wrf_rx_check
//  Purpose  : WR fabric receive-side test-frame checker (Eth/IPv4/UDP header
//             fields, payload pattern) with per-frame verdict and counters.
//  Options  : define WRF_RX_CSUM_EN to also verify the IPv4 header checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module wrf_rx_check #(
    parameter int          FRAME_WORDS  = 127,
    parameter logic [15:0] PAYLOAD_WORD = 16'h1234,
    parameter int          CNT_W        = 32
) (
    input  logic             wrf_clk,
    input  logic             wrf_rst_n,
    input  logic             wrf_valid,
    input  logic             wrf_last,
    input  logic [15:0]      wrf_data,
    output logic             wrf_ready,
    input  logic [47:0]      exp_dst_mac,
    input  logic [15:0]      exp_dst_port,
    input  logic             cnt_clear,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [3:0]       err_code,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_PAY    = 3'd2,
        S_DROP   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [6:0] c_last_idx     = 7'(FRAME_WORDS - 1);
    localparam logic [6:0] c_pay_idx      = 7'd21;
    localparam logic [3:0] c_err_dst_mac  = 4'd1;
    localparam logic [3:0] c_err_ethtype  = 4'd2;
    localparam logic [3:0] c_err_ip_ver   = 4'd3;
    localparam logic [3:0] c_err_proto    = 4'd4;
    localparam logic [3:0] c_err_udp_port = 4'd5;
    localparam logic [3:0] c_err_payload  = 4'd6;
    localparam logic [3:0] c_err_runt     = 4'd7;
    localparam logic [3:0] c_err_oversize = 4'd8;
    localparam logic [3:0] c_err_csum     = 4'd9;

    state_t     r_state;
    logic [6:0] r_idx;
    logic [3:0] r_code;

    logic       w_accept;
    logic       w_csum_bad;
    logic [3:0] w_fld_code;
    logic [3:0] w_beat_code;
    logic [3:0] w_frame_code;

    assign w_accept = wrf_valid & wrf_ready;

`ifdef WRF_RX_CSUM_EN
    // Ones-complement running sum over IPv4 header words 7..16, carry folded back each beat.
    logic [15:0] r_csum;
    logic [15:0] w_csum_base;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_fold;

    assign w_csum_base = (r_idx == 7'd7) ? 16'h0000 : r_csum;
    assign w_csum_sum  = {1'b0, w_csum_base} + {1'b0, wrf_data};
    assign w_csum_fold = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
    assign w_csum_bad  = (w_csum_fold != 16'hFFFF);

    always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
        if (!wrf_rst_n) begin
            r_csum <= 16'h0000;
        end else if (w_accept && (r_idx >= 7'd7) && (r_idx <= 7'd16)) begin
            r_csum <= w_csum_fold;
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    always_comb begin
        w_fld_code = 4'd0;
        case (r_idx)
            7'd0:    if (wrf_data != exp_dst_mac[47:32]) w_fld_code = c_err_dst_mac;
            7'd1:    if (wrf_data != exp_dst_mac[31:16]) w_fld_code = c_err_dst_mac;
            7'd2:    if (wrf_data != exp_dst_mac[15:0])  w_fld_code = c_err_dst_mac;
            7'd6:    if (wrf_data != 16'h0800)           w_fld_code = c_err_ethtype;
            7'd7:    if (wrf_data[15:8] != 8'h45)        w_fld_code = c_err_ip_ver;
            7'd11:   if (wrf_data[7:0] != 8'h11)         w_fld_code = c_err_proto;
            7'd16:   if (w_csum_bad)                     w_fld_code = c_err_csum;
            7'd18:   if (wrf_data != exp_dst_port)       w_fld_code = c_err_udp_port;
            default: if ((r_idx >= c_pay_idx) && (wrf_data != PAYLOAD_WORD))
                         w_fld_code = c_err_payload;
        endcase
    end

    // A field error on a beat outranks the length verdict for that same beat.
    always_comb begin
        w_beat_code = 4'd0;
        if (w_fld_code != 4'd0)
            w_beat_code = w_fld_code;
        else if (wrf_last && (r_idx < c_last_idx))
            w_beat_code = c_err_runt;
        else if (!wrf_last && (r_idx == c_last_idx))
            w_beat_code = c_err_oversize;
    end

    assign w_frame_code = (r_code != 4'd0) ? r_code : w_beat_code;

    always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
        if (!wrf_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= 7'd0;
            r_code    <= 4'd0;
            wrf_ready <= 1'b1;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 4'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_REPORT: begin
                    r_state   <= S_IDLE;
                    r_idx     <= 7'd0;
                    r_code    <= 4'd0;
                    wrf_ready <= 1'b1;
                end
                default: begin
                    if (w_accept) begin
                        if (r_idx != 7'h7F)
                            r_idx <= r_idx + 7'd1;
                        if (wrf_last) begin
                            r_state   <= S_REPORT;
                            wrf_ready <= 1'b0;
                            frame_ok  <= (w_frame_code == 4'd0);
                            frame_err <= (w_frame_code != 4'd0);
                            if (w_frame_code != 4'd0)
                                err_code <= w_frame_code;
                        end else if (w_frame_code != 4'd0) begin
                            r_state <= S_DROP;
                            r_code  <= w_frame_code;
                        end else if (r_idx >= (c_pay_idx - 7'd1)) begin
                            r_state <= S_PAY;
                        end else begin
                            r_state <= S_HDR;
                        end
                    end
                end
            endcase
        end
    end

    // Counters advance at the end of the report cycle so a same-cycle clear wins.
    always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
        if (!wrf_rst_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (cnt_clear) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (frame_ok && (ok_cnt != '1))
                ok_cnt <= ok_cnt + 1'b1;
            if (frame_err && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wrf_rx_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wrf_rx_check
//  Purpose  : Self-checking bench for wrf_rx_check: frame-level reference
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wrf_rx_check;

    localparam int          FW = 127;
    localparam logic [15:0] PW = 16'h1234;
    localparam int          CW = 4;

    logic          wrf_clk      = 1'b0;
    logic          wrf_rst_n    = 1'b1;
    logic          wrf_valid    = 1'b0;
    logic          wrf_last     = 1'b0;
    logic [15:0]   wrf_data     = 16'h0000;
    logic          wrf_ready;
    logic [47:0]   exp_dst_mac  = 48'h74563c4f4c6d;
    logic [15:0]   exp_dst_port = 16'h1000;
    logic          cnt_clear    = 1'b0;
    logic          frame_ok;
    logic          frame_err;
    logic [3:0]    err_code;
    logic [CW-1:0] ok_cnt;
    logic [CW-1:0] err_cnt;

    wrf_rx_check #(.FRAME_WORDS(FW), .PAYLOAD_WORD(PW), .CNT_W(CW)) dut (
        .wrf_clk      (wrf_clk),
        .wrf_rst_n    (wrf_rst_n),
        .wrf_valid    (wrf_valid),
        .wrf_last     (wrf_last),
        .wrf_data     (wrf_data),
        .wrf_ready    (wrf_ready),
        .exp_dst_mac  (exp_dst_mac),
        .exp_dst_port (exp_dst_port),
        .cnt_clear    (cnt_clear),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 wrf_clk = ~wrf_clk;

    int          n_vec    = 0;
    int          n_bad    = 0;
    bit          checking = 1'b0;
    logic [15:0] tx [0:511];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Verdict for a whole received frame, straight from the field rules.
    function automatic logic [3:0] eval_frame(input logic [15:0] w [0:511], input int n);
        logic [15:0] d;
        logic [47:0] mac;
`ifdef WRF_RX_CSUM_EN
        int s = 0;
`endif
        mac = exp_dst_mac;
        for (int i = 0; i < n; i++) begin
            d = w[i];
            if (i < 3 && d != 16'(mac >> (32 - 16 * i))) return 4'd1;
            if (i == 6 && d != 16'h0800) return 4'd2;
            if (i == 7 && d[15:8] != 8'h45) return 4'd3;
            if (i == 11 && d[7:0] != 8'h11) return 4'd4;
            if (i == 18 && d != exp_dst_port) return 4'd5;
            if (i >= 21 && d != PW) return 4'd6;
`ifdef WRF_RX_CSUM_EN
            if (i >= 7 && i <= 16) s += int'(d);
            if (i == 16) begin
                while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
                if (s != 32'hFFFF) return 4'd9;
            end
`endif
            if (i == n - 1 && i < FW - 1) return 4'd7;
            if (i != n - 1 && i == FW - 1) return 4'd8;
        end
        return 4'd0;
    endfunction

    // Header words 7..16 ones-complement sum to FFFF with F79A at word 12.
    task automatic build_good();
        logic [15:0] hdr [0:20];
        hdr = '{16'h7456, 16'h3c4f, 16'h4c6d, 16'h0200, 16'h0000, 16'h0001, 16'h0800,
                16'h4500, 16'h00F0, 16'h0000, 16'h0000, 16'h4011, 16'hF79A, 16'hC0A8,
                16'h0001, 16'hC0A8, 16'h0111, 16'h5000, 16'h1000, 16'h00DC, 16'h0000};
        for (int i = 0; i < 512; i++) tx[i] = (i < 21) ? hdr[i] : PW;
    endtask

    // Reference model: tracks acceptance, verdicts and counters from the stimulus alone.
    logic [15:0]   m_words [0:511];
    int            m_n     = 0;
    bit            m_ready = 1'b1;
    bit            m_ok    = 1'b0;
    bit            m_err   = 1'b0;
    logic [3:0]    m_code  = 4'd0;
    logic [CW-1:0] m_okc   = '0;
    logic [CW-1:0] m_errc  = '0;

    initial begin
        logic [3:0] c;
        forever begin
            @(posedge wrf_clk or negedge wrf_rst_n);
            if (!wrf_rst_n) begin
                m_n = 0; m_ready = 1'b1; m_ok = 1'b0; m_err = 1'b0;
                m_code = 4'd0; m_okc = '0; m_errc = '0;
            end else begin
                if (cnt_clear) begin
                    m_okc = '0; m_errc = '0;
                end else begin
                    if (m_ok && m_okc != '1) m_okc = m_okc + 1'b1;
                    if (m_err && m_errc != '1) m_errc = m_errc + 1'b1;
                end
                m_ok = 1'b0; m_err = 1'b0;
                if (wrf_valid && m_ready) begin
                    if (m_n < 512) m_words[m_n] = wrf_data;
                    m_n++;
                    m_ready = 1'b1;
                    if (wrf_last) begin
                        c = eval_frame(m_words, m_n);
                        m_n = 0;
                        m_ok = (c == 4'd0);
                        m_err = (c != 4'd0);
                        if (c != 4'd0) m_code = c;
                        m_ready = 1'b0;
                    end
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge wrf_clk);
            if (checking) begin
                check("ready",     32'(wrf_ready), 32'(m_ready));
                check("frame_ok",  32'(frame_ok),  32'(m_ok));
                check("frame_err", 32'(frame_err), 32'(m_err));
                check("err_code",  32'(err_code),  32'(m_code));
                check("ok_cnt",    32'(ok_cnt),    32'(m_okc));
                check("err_cnt",   32'(err_cnt),   32'(m_errc));
            end
        end
    end

    task automatic step();
        @(posedge wrf_clk);
        #1;
    endtask

    // Sends tx[0..n-1]; abort >= 0 asserts reset instead of presenting that beat.
    task automatic send_frame(input int n, input bit gaps, input int abort);
        for (int i = 0; i < n; i++) begin
            int  waits;
            bit  rdy;
            bit  done;
            if (i == abort) begin
                wrf_valid = 1'b0; wrf_last = 1'b0; wrf_rst_n = 1'b0;
                return;
            end
            if (gaps) begin
                int g = 0;
                while (g < 4 && $urandom_range(0, 2) == 0) begin
                    wrf_valid = 1'b0; step(); g++;
                end
            end
            wrf_valid = 1'b1; wrf_data = tx[i]; wrf_last = (i == n - 1);
            waits = 0; done = 1'b0;
            while (!done) begin
                rdy = wrf_ready;
                step();
                if (rdy) done = 1'b1;
                else if (++waits > 20) begin
                    n_vec++; n_bad++;
                    $display("FAIL beat_timeout: beat %0d not accepted in 20 cycles", i);
                    wrf_valid = 1'b0; wrf_last = 1'b0;
                    return;
                end
            end
        end
        wrf_valid = 1'b0; wrf_last = 1'b0;
    endtask

    initial begin
        #2 wrf_rst_n = 1'b0;
        #1 checking = 1'b1;
        check("rst_ready",   32'(wrf_ready), 32'd1);
        check("rst_ok",      32'(frame_ok),  32'd0);
        check("rst_code",    32'(err_code),  32'd0);
        check("rst_ok_cnt",  32'(ok_cnt),    32'd0);
        step(); step();
        wrf_rst_n = 1'b1;

        build_good();
        check("pin_good", 32'(eval_frame(tx, 127)), 32'd0);
        send_frame(127, 1'b0, -1);
        check("t1_frame_ok", 32'(frame_ok), 32'd1);
        step();
        check("t1_ok_cnt",  32'(ok_cnt),  32'd1);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        tx[6] = 16'h86DD; tx[40] = 16'h0000;
        check("pin_ethtype", 32'(eval_frame(tx, 127)), 32'd2);
        send_frame(127, 1'b0, -1);
        check("t2_frame_err", 32'(frame_err), 32'd1);
        check("t2_err_code",  32'(err_code),  32'd2);
        step();
        check("t2_err_cnt", 32'(err_cnt), 32'd1);

        build_good();
        check("pin_runt", 32'(eval_frame(tx, 51)), 32'd7);
        send_frame(51, 1'b0, -1);
        check("t3_err_code", 32'(err_code), 32'd7);

        check("pin_oversize", 32'(eval_frame(tx, 128)), 32'd8);
        send_frame(128, 1'b0, -1);
        check("t4_err_code", 32'(err_code), 32'd8);
        step();
        check("t4_err_cnt", 32'(err_cnt), 32'd3);

        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        send_frame(127, 1'b1, -1);
        send_frame(127, 1'b1, -1);
        tx[80] = 16'h1235;
        send_frame(127, 1'b1, -1);
        check("t5_err_code", 32'(err_code), 32'd6);
        step();
        check("t5_ok_cnt",  32'(ok_cnt),  32'd2);
        check("t5_err_cnt", 32'(err_cnt), 32'd1);

        build_good();
        send_frame(127, 1'b0, 60);
        #1;
        check("t6_rst_ready",   32'(wrf_ready), 32'd1);
        check("t6_rst_code",    32'(err_code),  32'd0);
        check("t6_rst_err_cnt", 32'(err_cnt),   32'd0);
        step();
        wrf_rst_n = 1'b1;
        send_frame(127, 1'b0, -1);
        check("t6_frame_ok", 32'(frame_ok), 32'd1);
        step();
        check("t6_ok_cnt", 32'(ok_cnt), 32'd1);

        tx[12] = 16'hF79B;
        send_frame(127, 1'b0, -1);
`ifdef WRF_RX_CSUM_EN
        check("t7_csum_code", 32'(err_code),  32'd9);
`else
        check("t7_csum_ign",  32'(frame_ok),  32'd1);
`endif
        step();

        build_good();
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        for (int k = 0; k < 15; k++) send_frame(127, 1'b0, -1);
        step();
        check("t8_ok_full", 32'(ok_cnt), 32'd15);
        send_frame(127, 1'b0, -1);
        step();
        check("t8_ok_sat", 32'(ok_cnt), 32'd15);
        send_frame(127, 1'b0, -1);
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        check("t8_clear_wins", 32'(ok_cnt), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
